// File: rtl/rs_pkg.sv
// -----------------------------------------------------------------------------
// rs_pkg -- shared definitions for the RS(204,188) encoder.
//   N, K, NPAR   : codeword length, message length, number of parity bytes
//   FIELD_POLY   : GF(2^8) reduction polynomial x^8+x^4+x^3+x^2+1
//   G[0..15]     : generator polynomial coefficients, G[i] multiplies x^i
//                  (the x^16 term is 1 and implicit)
//   state_t      : encoder phase (data pass-through vs parity flush)
//   gf_mul       : GF(2^8) multiply; with a constant operand this reduces
//                  to a pure XOR network
// -----------------------------------------------------------------------------
package rs_pkg;

    localparam int N    = 204;
    localparam int K    = 188;
    localparam int NPAR = 16;

    localparam logic [8:0] FIELD_POLY = 9'h11D;

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } state_t;

    typedef logic [NPAR-1:0][7:0] coef_vec_t;

    // Shift-and-add multiply in GF(2^8).
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ x;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? FIELD_POLY[7:0] : 8'h00);
        end
        return p;
    endfunction

    // g(x) = prod_{i=0..15} (x + alpha^i), alpha = 0x02.
    // Built up one root at a time; c[k] is the coefficient of x^k.
    function automatic coef_vec_t gen_poly();
        logic [7:0] c [0:NPAR];
        logic [7:0] root;
        coef_vec_t  res;
        for (int k = 0; k <= NPAR; k++) begin
            c[k] = 8'h00;
        end
        c[0] = 8'h01;
        root = 8'h01;
        for (int i = 0; i < NPAR; i++) begin
            for (int k = NPAR; k >= 1; k--) begin
                c[k] = c[k-1] ^ gf_mul(c[k], root);
            end
            c[0] = gf_mul(c[0], root);
            root = gf_mul(root, 8'h02);
        end
        for (int k = 0; k < NPAR; k++) begin
            res[k] = c[k];
        end
        return res;
    endfunction

    localparam coef_vec_t G = gen_poly();

endpackage

// File: rtl/rs_enc_if.sv
// -----------------------------------------------------------------------------
// rs_enc_if -- byte-stream bus of the RS encoder.
//   CE         : source strobe, one per byte slot
//   input_byte : message byte, valid with CE
//   Out_byte   : encoded byte, valid with CEO
//   CEO        : one-clk pulse per output byte
//   Valid_out  : output byte belongs to a codeword
//   Par_out    : output byte is a parity byte
// master = byte source/sink (testbench side), slave = encoder.
// -----------------------------------------------------------------------------
interface rs_enc_if;
    logic       CE;
    logic [7:0] input_byte;
    logic [7:0] Out_byte;
    logic       CEO;
    logic       Valid_out;
    logic       Par_out;

    modport master (
        output CE,
        output input_byte,
        input  Out_byte,
        input  CEO,
        input  Valid_out,
        input  Par_out
    );

    modport slave (
        input  CE,
        input  input_byte,
        output Out_byte,
        output CEO,
        output Valid_out,
        output Par_out
    );
endinterface

// File: rtl/gf_cmult.sv
// -----------------------------------------------------------------------------
// gf_cmult -- combinational GF(2^8) multiply by a constant C.
//   a_i : 8-bit operand
//   p_o : a_i * C in GF(2^8) mod 0x11D
// With C fixed at elaboration the multiply collapses to an XOR network.
// -----------------------------------------------------------------------------
module gf_cmult
    import rs_pkg::*;
#(
    parameter logic [7:0] C = 8'h01
) (
    input  logic [7:0] a_i,
    output logic [7:0] p_o
);

    assign p_o = gf_mul(a_i, C);

endmodule

// File: rtl/rs_enc.sv
// -----------------------------------------------------------------------------
// rs_enc -- systematic RS(204,188) encoder, t=8, GF(2^8) poly 0x11D.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : rs_enc_if.slave (CE/input_byte in; Out_byte/CEO/Valid_out/Par_out out)
// Each CE is one byte slot. Slots 0..187 pass the message byte through and
// clock the LFSR divider; slots 188..203 shift the 16 remainder bytes out,
// highest-degree (r15) first. The shift-out feeds zeros back, so the LFSR is
// already clear when the next codeword starts.
// -----------------------------------------------------------------------------
module rs_enc
    import rs_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    rs_enc_if.slave  bus
);

    localparam logic [7:0] SLOT_LAST_DATA = 8'(K - 1);
    localparam logic [7:0] SLOT_LAST      = 8'(N - 1);

    state_t     state_q;
    logic [7:0] cnt_q;
    logic [7:0] r_q [NPAR];
    logic [7:0] out_q;
    logic       ceo_q;
    logic       valid_q;
    logic       par_q;

    logic [7:0] fb;
    logic [7:0] gp [NPAR];

    // Feedback is forced to zero in the parity phase; every product is then
    // zero and the register chain degenerates into a plain shift.
    assign fb = (state_q == ST_DATA) ? (bus.input_byte ^ r_q[NPAR-1]) : 8'h00;

    generate
        for (genvar gi = 0; gi < NPAR; gi++) begin : g_cmult
            gf_cmult #(.C(G[gi])) u_cmult (
                .a_i (fb),
                .p_o (gp[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_DATA;
            cnt_q   <= 8'h00;
            out_q   <= 8'h00;
            ceo_q   <= 1'b0;
            valid_q <= 1'b0;
            par_q   <= 1'b0;
            for (int i = 0; i < NPAR; i++) begin
                r_q[i] <= 8'h00;
            end
        end else begin
            ceo_q <= bus.CE;
            if (bus.CE) begin
                valid_q <= 1'b1;
                par_q   <= (state_q == ST_PARITY);
                out_q   <= (state_q == ST_DATA) ? bus.input_byte : r_q[NPAR-1];

                r_q[0] <= gp[0];
                for (int i = 1; i < NPAR; i++) begin
                    r_q[i] <= r_q[i-1] ^ gp[i];
                end

                if (cnt_q == SLOT_LAST) begin
                    cnt_q <= 8'h00;
                end else begin
                    cnt_q <= cnt_q + 8'd1;
                end

                // Phase follows the slot that the counter is moving into.
                if (cnt_q == SLOT_LAST_DATA) begin
                    state_q <= ST_PARITY;
                end else if (cnt_q == SLOT_LAST) begin
                    state_q <= ST_DATA;
                end
            end
        end
    end

    assign bus.Out_byte  = out_q;
    assign bus.CEO       = ceo_q;
    assign bus.Valid_out = valid_q;
    assign bus.Par_out   = par_q;

endmodule

// File: tb/tb_rs_enc.sv
// -----------------------------------------------------------------------------
// tb_rs_enc -- scoreboard bench for rs_enc.
// The driver computes each codeword with a long-division reference encoder
// (log/antilog tables), pushes one expected entry per CE, and a negedge
// monitor pops and compares whenever CEO is high; between pulses it checks
// that outputs hold, and during reset that they are zero.
// -----------------------------------------------------------------------------
module tb_rs_enc;

    localparam int NB = 204;
    localparam int KB = 188;
    localparam int PB = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    rs_enc_if bus ();

    rs_enc dut (
        .clk   (clk),
        .reset (reset_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] b;
        logic       par;
    } exp_s;

    exp_s exp_q [$];

    int total = 0;
    int bad   = 0;

    int exp_t [0:509];
    int log_t [0:255];
    int gfull [0:16];
    int msg   [0:KB-1];
    int cw    [0:NB-1];

    logic       ce_seen;
    logic [7:0] last_out;
    logic       last_par;
    logic       last_valid;

    // ---------------- reference GF arithmetic ----------------
    function automatic int tmul(int a, int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[log_t[a] + log_t[b]];
    endfunction

    task automatic build_tables();
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = x;
            log_t[x] = i;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 'h11D;
        end
        for (int i = 255; i < 510; i++) exp_t[i] = exp_t[i-255];
        log_t[0] = 0;
        for (int k = 0; k <= 16; k++) gfull[k] = 0;
        gfull[0] = 1;
        for (int i = 0; i < PB; i++) begin
            for (int k = 16; k >= 1; k--) gfull[k] = gfull[k-1] ^ tmul(gfull[k], exp_t[i]);
            gfull[0] = tmul(gfull[0], exp_t[i]);
        end
    endtask

    // Codeword = message followed by remainder of m(x)*x^16 / g(x),
    // highest-degree coefficient first.
    task automatic compute_cw();
        int buff [0:NB-1];
        int coef;
        for (int i = 0; i < NB; i++) buff[i] = (i < KB) ? msg[i] : 0;
        for (int i = 0; i < KB; i++) begin
            coef = buff[i];
            if (coef != 0) begin
                for (int k = 0; k < PB; k++) buff[i+16-k] = buff[i+16-k] ^ tmul(coef, gfull[k]);
            end
        end
        for (int i = 0; i < NB; i++) cw[i] = (i < KB) ? msg[i] : buff[i];
    endtask

    // ---------------- driver ----------------
    task automatic drive_slot(input logic [7:0] b, input int gap);
        bus.CE = 1'b1;
        bus.input_byte = b;
        @(posedge clk); #1;
        bus.CE = 1'b0;
        bus.input_byte = 8'($urandom);
        repeat (gap - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_block(input string name, input int gap, input int nslots);
        exp_s e;
        compute_cw();
        for (int s = 0; s < nslots; s++) begin
            e.b   = 8'(cw[s]);
            e.par = (s >= KB);
            exp_q.push_back(e);
            // Parity slots get junk on input_byte; the encoder must ignore it.
            drive_slot((s < KB) ? 8'(msg[s]) : 8'($urandom), gap);
        end
        $display("block %s gap=%0d slots=%0d issued", name, gap, nslots);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d outputs still pending, required 0", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
        @(negedge clk); #1;
    endtask

    // ---------------- monitor ----------------
    function automatic void check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, req, $time);
        end
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ce_seen <= 1'b0;
        else          ce_seen <= bus.CE;
    end

    always @(negedge clk or negedge reset_n) begin
        if (reset_n !== 1'b1) begin
            #1;
            check("rst_out_byte",  int'(bus.Out_byte),  0);
            check("rst_ceo",       int'(bus.CEO),       0);
            check("rst_valid_out", int'(bus.Valid_out), 0);
            check("rst_par_out",   int'(bus.Par_out),   0);
            last_out   = 8'h00;
            last_par   = 1'b0;
            last_valid = 1'b0;
        end else begin
            check("ceo_latency", int'(bus.CEO), int'(ce_seen));
            if (bus.CEO === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ceo: got CEO=1 expected no output at %0t", $time);
                end else begin
                    exp_s e;
                    e = exp_q.pop_front();
                    check("out_byte",  int'(bus.Out_byte),  int'(e.b));
                    check("par_out",   int'(bus.Par_out),   int'(e.par));
                    check("valid_out", int'(bus.Valid_out), 1);
                end
                last_out   = bus.Out_byte;
                last_par   = bus.Par_out;
                last_valid = bus.Valid_out;
            end else begin
                check("hold_out_byte",  int'(bus.Out_byte),  int'(last_out));
                check("hold_par_out",   int'(bus.Par_out),   int'(last_par));
                check("hold_valid_out", int'(bus.Valid_out), int'(last_valid));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bus.CE = 1'b0;
        bus.input_byte = 8'h00;
        build_tables();

        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;

        // All-zero message: 204 zero bytes, parity flag on the last 16.
        for (int i = 0; i < KB; i++) msg[i] = 0;
        send_block("zeros", 1, NB);
        drain();

        // Impulse in the last data slot: parity is g15..g0.
        for (int i = 0; i < KB; i++) msg[i] = 0;
        msg[KB-1] = 1;
        send_block("impulse", 8, NB);
        drain();

        // Ramp with sparse and continuous strobes.
        for (int i = 0; i < KB; i++) msg[i] = i & 'hFF;
        send_block("ramp_sparse", 8, NB);
        send_block("ramp_cont", 1, NB);
        drain();

        // All-ones bytes, strobe every other clock.
        for (int i = 0; i < KB; i++) msg[i] = 'hFF;
        send_block("ones_gap2", 2, NB);
        drain();

        // Pseudo-random content, back-to-back with the previous one pending.
        for (int i = 0; i < KB; i++) msg[i] = (i * 37 + 11) & 'hFF;
        send_block("mix_a", 1, NB);
        for (int i = 0; i < KB; i++) msg[i] = int'($urandom_range(0, 255));
        send_block("rand_b", 3, NB);
        drain();

        // Reset mid-block at slot 100; next block must encode from slot 0.
        for (int i = 0; i < KB; i++) msg[i] = i & 'hFF;
        send_block("ramp_partial", 1, 100);
        drain();
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        send_block("ramp_after_reset", 1, NB);
        drain();

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rs_enc.md
RS_ENC -- requirements
Module: rs_enc

Interface
REQ-001 SHALL: clk  input  1  rising-edge system clock; sole clock domain.
REQ-002 SHALL: reset  input  1  asynchronous, active-low reset; all registers clear while low.
REQ-003 SHALL: CE  input  1  chip enable; high for one clk per byte slot; any spacing of at least one clk, including back-to-back.
REQ-004 SHALL: input_byte  input  8  message byte; sampled only on clk edges where CE=1.
REQ-005 SHALL: Out_byte  output  8  encoded codeword byte; registered.
REQ-006 SHALL: CEO  output  1  one-clk pulse marking a new Out_byte; asserted the clk after each sampled CE.
REQ-007 SHALL: Valid_out  output  1  high with every CEO that belongs to a codeword (all 204 slots).
REQ-008 SHALL: Par_out  output  1  high with CEO while Out_byte is a parity byte (slots 188..203).

Function
REQ-009 SHALL: implement systematic RS(204,188), t=8, over GF(2^8) with field polynomial x^8+x^4+x^3+x^2+1 (0x11D); g(x)=prod_{i=0..15}(x+alpha^i), alpha=0x02; bit-exact with RS_dec.
REQ-010 SHALL: each codeword uses exactly 204 CE strobes: slots 0..187 carry data; slots 188..203 carry parity, and input_byte is ignored in those slots.
REQ-011 SHALL: keep a slot counter 0..203 that advances by one per CE and wraps from 203 to 0 on the same edge; the counter holds when CE=0.
REQ-012 SHALL: state machine DATA (counter 0..187) -> PARITY (counter 188..203) -> DATA; transitions occur only on CE edges.
REQ-013 SHALL: in DATA, fb = input_byte XOR r15; r_i <= r_{i-1} XOR g_i*fb for i=1..15; r0 <= g0*fb; Out_byte <= input_byte.
REQ-014 SHALL: in PARITY, Out_byte <= r15, registers shift up with zero feedback (r_i <= r_{i-1}, r0 <= 0).
REQ-015 SHALL: after slot 203 the LFSR is all-zero, so the next codeword starts with no extra clear cycle.
REQ-016 SHALL: latency is one clk from CE to CEO/Out_byte; throughput is one byte per clk with CE held high.
REQ-017 SHALL: hold Out_byte, and hold Valid_out and Par_out at their last values, between CEO pulses; CEO is 0 whenever CE was 0 on the previous edge.
REQ-018 SHALL: Valid_out goes high on the first CEO after reset and stays high for all subsequent CEO pulses.
REQ-019 SHALL: GF constant multiplies are pure XOR networks; the block contains no lookup-table RAM.

Reset
REQ-020 SHALL: on reset low, Out_byte=0x00, CEO=0, Valid_out=0, Par_out=0, counter=0, state=DATA, r0..r15=0x00, asynchronously.
REQ-021 SHALL: reset asserted mid-codeword discards the partial block; the first CE after release is data slot 0.

Structure
REQ-022 SHALL: shared package rs_pkg holds N=204, K=188, NPAR=16, FIELD_POLY=0x11D, generator coefficient array G[0..15], and the state enum.
REQ-023 SHALL: one sub-module gf_cmult (8-bit input times parameter constant, combinational) is instantiated 16 times; there are no other sub-modules.

Verification
REQ-024 SHALL: all-zero 188-byte block -> 204 zero bytes; Par_out high on exactly the last 16 CEO pulses.
REQ-025 SHALL: slot 187=0x01, all other data 0x00 -> parity bytes equal G[15],G[14],...,G[0] in order (g15 first).
REQ-026 SHALL: 100 random blocks, CE every 8 clks -> stream fed into RS_dec reproduces all 18800 data bytes with 0 errors; results match a software reference encoder byte-for-byte.
REQ-027 SHALL: same as REQ-026 with CE held continuously high -> identical Out_byte sequence, CEO every clk, 1-clk latency.
REQ-028 SHALL: reset pulsed low at slot 100 -> outputs zero immediately; the next block encodes identically to a fresh-reset run.
REQ-029 SHALL: encoded blocks with 8 random byte corruptions per block -> RS_dec corrects them all; with 9 corruptions the bench flags an uncorrectable block.
